// File: rtl/mem_dump_reader.sv
// mem_dump_reader: once the CPU raises done, take the data-memory bus,
// read DUMP_LEN bytes starting at BASE_ADDR, and stream them out over a
// valid/ready byte port.
// Optional feature macro: MEM_DUMP_CHECKSUM_EN appends an XOR checksum byte.
module mem_dump_reader #(
  parameter logic [7:0]  BASE_ADDR = 8'h80,
  parameter int unsigned DUMP_LEN  = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       done,
  output logic       mem_grant,
  output logic [7:0] mem_address,
  input  logic [7:0] mem_data,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  input  logic       out_ready,
  output logic       busy,
  output logic       finished
);

  localparam int unsigned AW = 8;
  localparam logic [AW-1:0] LEN_M1 = AW'(DUMP_LEN - 1);

`ifdef MEM_DUMP_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, FIN, CHK} state_e;
`else
  typedef enum logic [2:0] {IDLE, REQ, CAPT, SEND, FIN} state_e;
`endif

  state_e        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          last_q, last_d;
  logic          busy_q, busy_d;
  logic          fin_q, fin_d;
`ifdef MEM_DUMP_CHECKSUM_EN
  logic [7:0]    csum_q, csum_d;
`endif

  // Next-state, counter and registered-output computation.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
    csum_d  = csum_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (done) begin
          state_d = REQ;
          addr_d  = BASE_ADDR;
          cnt_d   = LEN_M1;
        end
      end
      REQ:  state_d = CAPT;
      CAPT: begin
        data_d  = mem_data;
        state_d = SEND;
      end
      SEND: begin
        if (out_ready) begin
`ifdef MEM_DUMP_CHECKSUM_EN
          csum_d = csum_q ^ data_q;
`endif
          if (cnt_q == '0) begin
`ifdef MEM_DUMP_CHECKSUM_EN
            state_d = CHK;
            data_d  = csum_q ^ data_q;
`else
            state_d = FIN;
`endif
          end else begin
            addr_d  = addr_q + AW'(1);
            cnt_d   = cnt_q - AW'(1);
            state_d = REQ;
          end
        end
      end
`ifdef MEM_DUMP_CHECKSUM_EN
      CHK: begin
        if (out_ready) state_d = FIN;
      end
`endif
      FIN:     state_d = FIN;
      default: state_d = IDLE;
    endcase

    grant_d = (state_d == REQ) || (state_d == CAPT) || (state_d == SEND);
    fin_d   = (state_d == FIN);
`ifdef MEM_DUMP_CHECKSUM_EN
    busy_d  = grant_d || (state_d == CHK);
    valid_d = (state_d == SEND) || (state_d == CHK);
    last_d  = (state_d == CHK);
`else
    busy_d  = grant_d;
    valid_d = (state_d == SEND);
    last_d  = (state_d == SEND) && (cnt_d == '0);
`endif
  end

  // State, counters and outputs; async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      grant_q <= 1'b0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      fin_q   <= 1'b0;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      grant_q <= grant_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      fin_q   <= fin_d;
`ifdef MEM_DUMP_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_grant   = grant_q;
  assign mem_address = addr_q;
  assign out_valid   = valid_q;
  assign out_data    = data_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign finished    = fin_q;

endmodule

// File: tb/tb_mem_dump_reader.sv
// Directed testbench for mem_dump_reader: default instance (80h, 16 bytes)
// plus a wrapping instance (FEh, 4 bytes), each with a registered RAM model.
module tb_mem_dump_reader;

`ifdef MEM_DUMP_CHECKSUM_EN
  localparam int CS = 1;
`else
  localparam int CS = 0;
`endif
  localparam int N_MAIN = 16 + CS;
  localparam int N_W    = 4 + CS;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       done = 1'b0, done2 = 1'b0;
  logic       out_ready = 1'b0, ready2 = 1'b0;
  logic       mem_grant, w_grant;
  logic [7:0] mem_address, w_address;
  logic [7:0] mem_data = 8'h00, w_mem_data = 8'h00;
  logic       out_valid, w_valid;
  logic [7:0] out_data, w_data;
  logic       out_last, w_last;
  logic       busy, w_busy;
  logic       finished, w_finished;

  logic [7:0] ram   [256];
  logic [7:0] ram_w [256];
  logic [7:0] exp_w [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h0F};

  int total = 0;
  int bad = 0;

  always #5 clock = ~clock;

  mem_dump_reader dut (
    .clock(clock), .reset(reset), .done(done),
    .mem_grant(mem_grant), .mem_address(mem_address), .mem_data(mem_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy), .finished(finished)
  );

  mem_dump_reader #(.BASE_ADDR(8'hFE), .DUMP_LEN(4)) dut_w (
    .clock(clock), .reset(reset), .done(done2),
    .mem_grant(w_grant), .mem_address(w_address), .mem_data(w_mem_data),
    .out_valid(w_valid), .out_data(w_data), .out_last(w_last),
    .out_ready(ready2), .busy(w_busy), .finished(w_finished)
  );

  // Registered-read RAM models.
  always @(posedge clock) begin
    mem_data   <= ram[mem_address];
    w_mem_data <= ram_w[w_address];
  end

  function automatic logic [7:0] exp_main(input int i);
    return (i < 16) ? 8'(8'h10 + i) : 8'h00;
  endfunction

  // Receive from the main instance: stop after 'stop' transfers of an n-byte stream.
  task automatic rx_main(input int n, input int stop, input bit rnd,
                         input bit spacing, input int first_cyc);
    int got = 0;
    int cyc = 0;
    int last_x = -1;
    bit stall = 0;
    logic [7:0] held = 8'h00;
    while (got < stop && cyc < 2000) begin
      @(negedge clock);
      cyc++;
      if (stall) begin
        total++;
        if (out_valid !== 1'b1 || out_data !== held) begin
          bad++;
          $display("FAIL hold got v=%b d=%h exp v=1 d=%h", out_valid, out_data, held);
        end
      end
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      stall = 0;
      if (out_valid === 1'b1) begin
        if (got == 0 && first_cyc > 0) begin
          total++;
          if (cyc != first_cyc) begin
            bad++;
            $display("FAIL first_valid got cyc=%0d exp=%0d", cyc, first_cyc);
          end
        end
        if (out_ready) begin
          total++;
          if (out_data !== exp_main(got) || out_last !== (got == n - 1)) begin
            bad++;
            $display("FAIL byte%0d got d=%h l=%b exp d=%h l=%b", got, out_data,
                     out_last, exp_main(got), (got == n - 1));
          end
          if (spacing && last_x >= 0) begin
            total++;
            if (cyc - last_x != 3) begin
              bad++;
              $display("FAIL spacing got=%0d exp=3", cyc - last_x);
            end
          end
          last_x = cyc;
          got++;
        end else begin
          stall = 1;
          held = out_data;
        end
      end
    end
    if (got < stop) begin
      total++;
      bad++;
      $display("FAIL rx_timeout got=%0d exp=%0d", got, stop);
    end
  endtask

  task automatic check_reset_vals(input string name);
    total++;
    if ({mem_grant, mem_address, out_valid, out_data, out_last, busy, finished} !== 21'h0) begin
      bad++;
      $display("FAIL %s got g=%b a=%h v=%b d=%h l=%b b=%b f=%b exp all 0", name,
               mem_grant, mem_address, out_valid, out_data, out_last, busy, finished);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    check_reset_vals("reset_asserted");
    reset = 1'b1;
    @(negedge clock);
    check_reset_vals("idle_no_done");
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    done = 1'b1;
    @(negedge clock);
    total++;
    if (mem_grant !== 1'b1 || mem_address !== 8'h80 || busy !== 1'b1 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL start got g=%b a=%h b=%b v=%b exp g=1 a=80 b=1 v=0",
               mem_grant, mem_address, busy, out_valid);
    end
    @(negedge clock);
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL early_valid got=%b exp=0", out_valid);
    end
    rx_main(N_MAIN, N_MAIN, 1'b0, 1'b1, 1);
    repeat (2) @(negedge clock);
    total++;
    if (finished !== 1'b1 || mem_grant !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL end_state got f=%b g=%b b=%b v=%b exp f=1 g=0 b=0 v=0",
               finished, mem_grant, busy, out_valid);
    end
  endtask

  task automatic test_no_restart();
    bit saw_valid = 0;
    bit lost_fin = 0;
    done = 1'b0;
    repeat (2) @(negedge clock);
    done = 1'b1;
    repeat (20) begin
      @(negedge clock);
      if (out_valid !== 1'b0 || mem_grant !== 1'b0) saw_valid = 1;
      if (finished !== 1'b1) lost_fin = 1;
    end
    total++;
    if (saw_valid || lost_fin) begin
      bad++;
      $display("FAIL no_restart got restart=%b lost_fin=%b exp 0 0", saw_valid, lost_fin);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_vals("reset_after_fin");
    reset = 1'b1;
    rx_main(N_MAIN, N_MAIN, 1'b0, 1'b1, 3);
    repeat (2) @(negedge clock);
    total++;
    if (finished !== 1'b1) begin
      bad++;
      $display("FAIL redump_fin got=%b exp=1", finished);
    end
  endtask

  task automatic test_backpressure();
    done = 1'b0;
    pulse_reset();
    done = 1'b1;
    rx_main(N_MAIN, N_MAIN, 1'b1, 1'b0, 0);
    repeat (2) @(negedge clock);
    total++;
    if (finished !== 1'b1 || mem_grant !== 1'b0) begin
      bad++;
      $display("FAIL bp_end got f=%b g=%b exp f=1 g=0", finished, mem_grant);
    end
  endtask

  task automatic test_reset_mid();
    int k = 0;
    done = 1'b0;
    pulse_reset();
    done = 1'b1;
    rx_main(N_MAIN, 4, 1'b0, 1'b1, 0);
    @(negedge clock);
    out_ready = 1'b0;
    while (out_valid !== 1'b1 && k < 10) begin
      @(negedge clock);
      k++;
    end
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h14 || mem_grant !== 1'b1) begin
      bad++;
      $display("FAIL fifth_byte got v=%b d=%h g=%b exp v=1 d=14 g=1", out_valid, out_data, mem_grant);
    end
    #2 reset = 1'b0;
    #1 check_reset_vals("reset_mid_dump");
    @(negedge clock);
    reset = 1'b1;
    rx_main(N_MAIN, N_MAIN, 1'b0, 1'b1, 3);
    repeat (2) @(negedge clock);
    total++;
    if (finished !== 1'b1) begin
      bad++;
      $display("FAIL mid_redump_fin got=%b exp=1", finished);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] addrs [4];
    logic [7:0] prev = 8'h00;
    bit have = 0;
    int na = 0;
    int nb = 0;
    int cyc = 0;
    logic [7:0] exp_a [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    for (int i = 0; i < 4; i++) addrs[i] = 8'h00;
    ready2 = 1'b1;
    done2 = 1'b1;
    while (w_finished !== 1'b1 && cyc < 200) begin
      @(negedge clock);
      cyc++;
      if (w_grant === 1'b1 && (!have || w_address !== prev)) begin
        if (na < 4) addrs[na] = w_address;
        na++;
        prev = w_address;
        have = 1;
      end
      if (w_valid === 1'b1) begin
        total++;
        if (nb >= N_W || w_data !== exp_w[nb] || w_last !== (nb == N_W - 1)) begin
          bad++;
          $display("FAIL wrap_byte%0d got d=%h l=%b exp d=%h l=%b", nb, w_data, w_last,
                   (nb < N_W) ? exp_w[nb] : 8'hxx, (nb == N_W - 1));
        end
        nb++;
      end
    end
    total++;
    if (na != 4 || nb != N_W || w_finished !== 1'b1) begin
      bad++;
      $display("FAIL wrap_counts got na=%0d nb=%0d f=%b exp na=4 nb=%0d f=1", na, nb, w_finished, N_W);
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (addrs[i] !== exp_a[i]) begin
        bad++;
        $display("FAIL wrap_addr%0d got=%h exp=%h", i, addrs[i], exp_a[i]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      ram[i]   = 8'(i ^ 8'h5A);
      ram_w[i] = 8'hEE;
    end
    for (int i = 0; i < 16; i++) ram[8'h80 + i] = 8'(8'h10 + i);
    ram_w[8'hFE] = 8'h01;
    ram_w[8'hFF] = 8'h02;
    ram_w[8'h00] = 8'h04;
    ram_w[8'h01] = 8'h08;

    test_reset();
    test_basic();
    test_no_restart();
    test_backpressure();
    test_reset_mid();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
